// File: rtl/gemm_result_collector_if.sv
// Bus between the systolic-array output stage, the result collector and its consumer.
// Optional row tagging (result_row, matrix_done) exists only with GEMM_RESULT_COLLECTOR_ROW_TAG_EN.
interface gemm_result_collector_if #(
    parameter int SA_SIZE                = 3,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH             = 4
);
    // Result side is valid/ready: a vector transfers on any rising clk edge where
    // result_valid and result_ready are both high. result_valid and result_data never
    // change while result_valid=1 and result_ready=0, and result_valid does not wait
    // for result_ready.
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_outputs;
    logic                                           sa_output_valid;
    logic                                           capture_en;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] result_data;
    logic                                           result_valid;
    logic                                           result_ready;
    logic [$clog2(FIFO_DEPTH):0]                    fifo_count;
    logic                                           overflow;
    logic                                           dbg_state;
`ifdef GEMM_RESULT_COLLECTOR_ROW_TAG_EN
    logic [$clog2(SA_SIZE)-1:0]                     result_row;
    logic                                           matrix_done;
`endif

    modport master (
        output sa_outputs, sa_output_valid, capture_en, result_ready,
        input  result_data, result_valid, fifo_count, overflow, dbg_state
`ifdef GEMM_RESULT_COLLECTOR_ROW_TAG_EN
        , input result_row, matrix_done
`endif
    );

    modport slave (
        input  sa_outputs, sa_output_valid, capture_en, result_ready,
        output result_data, result_valid, fifo_count, overflow, dbg_state
`ifdef GEMM_RESULT_COLLECTOR_ROW_TAG_EN
        , output result_row, matrix_done
`endif
    );
endinterface

// File: rtl/gemm_result_collector.sv
// Captures systolic-array output vectors into a small FIFO and streams them out on valid/ready.
// Define GEMM_RESULT_COLLECTOR_ROW_TAG_EN to tag each vector with its row index within the matrix.
module gemm_result_collector #(
    parameter int SA_SIZE                = 3,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    gemm_result_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] vec_t;
    typedef enum logic {WAIT_VALID = 1'b0, STREAM = 1'b1} state_t;

    state_t        state;
    vec_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic push_req;
    logic pop;
    logic full;
    logic do_push;

    // The first valid cycle only arms STREAM, so it is never captured.
    assign push_req = (state == STREAM) && bus.sa_output_valid && bus.capture_en;
    assign pop      = (count != '0) && bus.result_ready;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_push  = push_req && (!full || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= WAIT_VALID;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                WAIT_VALID: if (bus.sa_output_valid) state <= STREAM;
                STREAM:     if (!bus.sa_output_valid) state <= WAIT_VALID;
                default:    state <= WAIT_VALID;
            endcase
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
            if (push_req && !do_push) ovf <= 1'b1;
        end
    end

    // Storage is cleared on reset so result_data reads zero and no stale vector survives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= bus.sa_outputs;
        end
    end

    assign bus.result_data  = mem[rd_ptr];
    assign bus.result_valid = (count != '0);
    assign bus.fifo_count   = count;
    assign bus.overflow     = ovf;
    assign bus.dbg_state    = state;

`ifdef GEMM_RESULT_COLLECTOR_ROW_TAG_EN
    localparam int RW = $clog2(SA_SIZE);

    logic [RW-1:0] row_cnt;
    logic [RW-1:0] tag_mem [FIFO_DEPTH];

    // Dropped vectors still consume a row slot so tags stay aligned with the matrix.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_cnt <= '0;
        end else if (state == STREAM && !bus.sa_output_valid) begin
            row_cnt <= '0;
        end else if (push_req) begin
            row_cnt <= (row_cnt == RW'(SA_SIZE - 1)) ? '0 : row_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) tag_mem[i] <= '0;
        end else if (do_push) begin
            tag_mem[wr_ptr] <= row_cnt;
        end
    end

    assign bus.result_row  = tag_mem[rd_ptr];
    assign bus.matrix_done = pop && (tag_mem[rd_ptr] == RW'(SA_SIZE - 1));
`endif
endmodule

// File: doc/gemm_result_collector.md
GEMM_RESULT_COLLECTOR -- requirements
Module: gemm_result_collector

Interface
REQ-001 The block SHALL have parameter SA_SIZE, default 3, giving the number of systolic-array output columns per result vector.
REQ-002 The block SHALL have parameter WEIGHT_ACTIVATION_SIZE, default 8, giving the bit width of each output element.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of result vectors buffered; it must be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port sa_outputs, input, SA_SIZE x WEIGHT_ACTIVATION_SIZE, the array output vector.
REQ-007 The block SHALL have port sa_output_valid, input, 1 bit, indicating the array output is valid.
REQ-008 The block SHALL have port capture_en, input, 1 bit, qualifying that sa_outputs holds a new vector this cycle.
REQ-009 The block SHALL have port result_data, output, SA_SIZE x WEIGHT_ACTIVATION_SIZE, the head-of-FIFO vector.
REQ-010 The block SHALL have port result_valid, output, 1 bit, indicating result_data is valid.
REQ-011 The block SHALL have port result_ready, input, 1 bit, downstream acceptance.
REQ-012 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, the current occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit, a sticky flag marking a dropped vector.

Function
REQ-014 The FSM SHALL have two states, WAIT_VALID and STREAM.
REQ-015 WAIT_VALID SHALL move to STREAM on the cycle sa_output_valid=1 is sampled; STREAM SHALL return to WAIT_VALID on any cycle sa_output_valid=0.
REQ-016 A push SHALL occur only when the state is STREAM, sa_output_valid=1 and capture_en=1; capture_en is ignored in WAIT_VALID, so the first valid cycle is never captured.
REQ-017 A pushed vector SHALL be stored in full, with all SA_SIZE elements taken from the same cycle, without modification or reordering.
REQ-018 A pop SHALL occur when result_valid=1 and result_ready=1; result_valid SHALL equal (fifo_count != 0).
REQ-019 result_data SHALL present the oldest stored vector, available the cycle after its push, and SHALL hold stable while result_valid=1 and result_ready=0.
REQ-020 Push to an empty FIFO SHALL give result_valid=1 on the next cycle; there is no combinational bypass.
REQ-021 On push while full without a simultaneous pop, the vector SHALL be dropped, fifo_count SHALL be unchanged, and overflow SHALL be set.
REQ-022 On push and pop in the same cycle, including when full or when the count is 1, both SHALL take effect and fifo_count SHALL be unchanged.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 While resetn=0, the state SHALL be WAIT_VALID, pointers=0, fifo_count=0, result_valid=0, overflow=0, and result_data=0.
REQ-026 Reset asserted mid-stream SHALL discard all buffered vectors immediately, without waiting for a clock edge.
REQ-027 The first push after reset deassertion SHALL require the WAIT_VALID to STREAM transition again.

Configuration
REQ-028 With macro GEMM_RESULT_COLLECTOR_ROW_TAG_EN defined, the block SHALL add output result_row, $clog2(SA_SIZE) bits, and output matrix_done, 1 bit; without the macro, neither port nor its logic exists.
REQ-029 With the macro defined, each pushed vector SHALL store a row tag from a counter that counts 0..SA_SIZE-1 and wraps.
REQ-030 With the macro defined, the row counter SHALL reset to 0 on reset and on the return to WAIT_VALID, and a dropped vector SHALL still advance it.
REQ-031 With the macro defined, result_row SHALL accompany result_data, and matrix_done SHALL pulse for 1 cycle on a pop whose tag is SA_SIZE-1.

Verification
REQ-032 The bench SHALL cover: SA_SIZE=2, valid rises, then capture pushes {6,10} then {9,4} with result_ready=1 -> result_data {6,10} then {9,4} on consecutive cycles, fifo_count never above 1.
REQ-033 The bench SHALL cover: result_ready=0 and 5 captures with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, and the pop order is the first 4 vectors.
REQ-034 The bench SHALL cover: full FIFO with simultaneous push and pop -> fifo_count stays 4, overflow stays 0, and the new vector is last out.
REQ-035 The bench SHALL cover: resetn pulsed low with 3 vectors buffered -> result_valid=0 and fifo_count=0 during reset, and no old data after release.
REQ-036 The bench SHALL cover: sa_output_valid drops for 1 cycle mid-stream -> no push that cycle or on the next valid cycle, then captures resume.
REQ-037 The bench SHALL cover, with the macro defined and SA_SIZE=3: 6 captures -> result_row 0,1,2,0,1,2, with matrix_done on the 3rd and 6th pops.
